// File: rtl/exmem_pkg.sv
// Shared definitions for the external-memory initiator: FSM encoding and
// bus constants.
package exmem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [31:0] WORD_BYTES = 32'd4;
    localparam logic [3:0]  SEL_ALL    = 4'hF;

endpackage

// File: rtl/exmem_rd_fifo.sv
// Synchronous read-data FIFO with occupancy count; simultaneous push and pop
// leave the count unchanged.
module exmem_rd_fifo #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] dout,
    output logic              empty,
    output logic              full,
    output logic [AW:0]       count
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage is data-only and needs no reset; pointers wrap naturally mod DEPTH.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/exmem_initiator.sv
// Command-driven burst initiator for a pipelined, in-order-ack memory; read
// issue is throttled so every outstanding read has a guaranteed FIFO slot.
module exmem_initiator
    import exmem_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int LEN_W = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_we,
    input  logic [31:0]      cmd_addr,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             wdata_valid,
    output logic             wdata_ready,
    input  logic [31:0]      wdata,
    output logic             rdata_valid,
    input  logic             rdata_ready,
    output logic [31:0]      rdata,
    output logic             busy,
    output logic             done,
    output logic             m_stb,
    output logic             m_we,
    output logic [3:0]       m_sel,
    output logic [31:0]      m_addr,
    output logic [31:0]      m_dat_o,
    input  logic             m_ack,
    input  logic [31:0]      m_dat_i
);

    state_t           state, state_nxt;
    logic             done_nxt;
    logic             we_q;
    logic [31:0]      addr_q;
    logic [LEN_W-1:0] remaining;
    logic [LEN_W:0]   outstanding;
    logic [AW:0]      fifo_count;
    logic             fifo_empty;
    logic             fifo_full;
    logic             accept;
    logic             issue;
    logic             ack_v;
    logic             rd_room;
    logic             can_issue;

    assign cmd_ready   = (state == IDLE);
    assign busy        = (state != IDLE);
    assign accept      = cmd_valid && cmd_ready;
    assign can_issue   = (state == ISSUE) && (remaining != '0);
    assign wdata_ready = can_issue && we_q;
    // Counting in-flight reads against free FIFO slots makes overflow impossible.
    assign rd_room     = ((LEN_W+2)'(outstanding) + (LEN_W+2)'(fifo_count)) < (LEN_W+2)'(DEPTH);
    assign issue       = can_issue && (we_q ? wdata_valid : rd_room);
    assign ack_v       = m_ack && (outstanding != '0);
    assign rdata_valid = !fifo_empty;

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (cmd_len != '0) begin
                        state_nxt = ISSUE;
                    end else begin
                        done_nxt = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (issue && (remaining == LEN_W'(1))) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (outstanding == '0) begin
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            done        <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            remaining   <= '0;
            outstanding <= '0;
            m_stb       <= 1'b0;
            m_we        <= 1'b0;
            m_sel       <= '0;
            m_addr      <= '0;
            m_dat_o     <= '0;
        end else begin
            state <= state_nxt;
            done  <= done_nxt;
            m_stb <= issue;
            m_we  <= issue && we_q;
            m_sel <= issue ? SEL_ALL : 4'h0;
            if (accept) begin
                we_q      <= cmd_we;
                addr_q    <= cmd_addr;
                remaining <= cmd_len;
            end
            if (issue) begin
                m_addr    <= addr_q;
                m_dat_o   <= we_q ? wdata : 32'h0;
                addr_q    <= addr_q + WORD_BYTES;
                remaining <= remaining - 1'b1;
            end
            case ({issue, ack_v})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    exmem_rd_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (32)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (ack_v && !we_q),
        .din   (m_dat_i),
        .pop   (rdata_ready),
        .dout  (rdata),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

endmodule
